// File: rtl/arith_sitofp_pipe_pkg.sv
// Float format constants shared by the arith conversion blocks.
// Widths are looked up by total float width (32 = binary32, 64 = binary64).
package arith_fp_pkg;

    localparam int SP_EXP_W  = 8;
    localparam int SP_MANT_W = 23;
    localparam int SP_BIAS   = 127;
    localparam int DP_EXP_W  = 11;
    localparam int DP_MANT_W = 52;
    localparam int DP_BIAS   = 1023;

    function automatic bit fp_fmt_ok(input int width);
        return (width == 32) || (width == 64);
    endfunction

    function automatic int fp_exp_w(input int width);
        return (width == 64) ? DP_EXP_W : SP_EXP_W;
    endfunction

    function automatic int fp_mant_w(input int width);
        return (width == 64) ? DP_MANT_W : SP_MANT_W;
    endfunction

    function automatic int fp_bias(input int width);
        return (width == 64) ? DP_BIAS : SP_BIAS;
    endfunction

endpackage

// File: rtl/arith_sitofp_pipe_if.sv
// Producer/consumer handshake channels of the sitofp pipeline.
// The pipeline uses the slave view; its environment uses the master view.
interface arith_sitofp_pipe_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32
);
    logic                 a_valid;
    logic                 a_ready;
    logic [IN_WIDTH-1:0]  a_data;
    logic                 result_valid;
    logic                 result_ready;
    logic [OUT_WIDTH-1:0] result_data;

    modport master (
        output a_valid, a_data, result_ready,
        input  a_ready, result_valid, result_data
    );

    modport slave (
        input  a_valid, a_data, result_ready,
        output a_ready, result_valid, result_data
    );
endinterface

// File: rtl/arith_sitofp_pipe_lzc.sv
// Combinational leading-zero counter; count is WIDTH when the input is all zeros.
// Shared by arith blocks that need normalisation.
module arith_lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit is the last to write the count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/arith_sitofp_pipe.sv
// Signed integer to IEEE-754 float, 3-stage valid/ready pipeline with RNE rounding.
// Define ARITH_SITOFP_SKID_EN for a registered a_ready via a 2-entry input skid buffer.
module arith_sitofp_pipe
    import arith_fp_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    arith_sitofp_pipe_if.slave io
);

    localparam int EXP_W  = fp_exp_w(OUT_WIDTH);
    localparam int MANT_W = fp_mant_w(OUT_WIDTH);
    localparam int BIAS   = fp_bias(OUT_WIDTH);
    localparam int LZC_W  = $clog2(IN_WIDTH + 1);
    localparam int EXT_W  = IN_WIDTH + MANT_W + 1;

    if (!fp_fmt_ok(OUT_WIDTH)) begin : g_bad_fmt
        $fatal(1, "arith_sitofp_pipe: OUT_WIDTH must be 32 or 64");
    end
    if (IN_WIDTH < 8 || IN_WIDTH > 64) begin : g_bad_in
        $fatal(1, "arith_sitofp_pipe: IN_WIDTH must be within 8..64");
    end

    logic                in_valid;
    logic [IN_WIDTH-1:0] in_data;
    logic                s1_ready;
    logic                s2_ready;
    logic                s3_ready;

`ifdef ARITH_SITOFP_SKID_EN
    logic [IN_WIDTH-1:0] skid_mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          skid_count;
    logic [1:0]          skid_count_next;
    logic                a_ready_q;
    logic                push;
    logic                pop;

    assign push     = io.a_valid && a_ready_q;
    assign pop      = in_valid && s1_ready;
    assign in_valid = (skid_count != 2'd0);
    assign in_data  = skid_mem[rd_ptr];
    assign io.a_ready = a_ready_q;

    always_comb begin
        skid_count_next = skid_count;
        case ({push, pop})
            2'b10:   skid_count_next = skid_count + 2'd1;
            2'b01:   skid_count_next = skid_count - 2'd1;
            default: skid_count_next = skid_count;
        endcase
    end

    // a_ready comes straight from a flop, breaking the result_ready -> a_ready path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            skid_count <= 2'd0;
            a_ready_q  <= 1'b1;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            skid_count <= skid_count_next;
            a_ready_q  <= (skid_count_next != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (push) skid_mem[wr_ptr] <= io.a_data;
    end
`else
    assign in_valid   = io.a_valid;
    assign in_data    = io.a_data;
    assign io.a_ready = s1_ready;
`endif

    logic                 s1_valid;
    logic                 s1_sign;
    logic [IN_WIDTH-1:0]  s1_mag;
    logic                 s2_valid;
    logic                 s2_sign;
    logic                 s2_zero;
    logic [LZC_W-1:0]     s2_lzc;
    logic [IN_WIDTH-2:0]  s2_frac;
    logic                 s3_valid;
    logic [OUT_WIDTH-1:0] s3_data;

    assign s3_ready = !s3_valid || io.result_ready;
    assign s2_ready = !s2_valid || s3_ready;
    assign s1_ready = !s1_valid || s2_ready;

    // Negating INT_MIN wraps to 2^(IN_WIDTH-1), which is the correct unsigned magnitude.
    logic [IN_WIDTH-1:0] mag_in;
    assign mag_in = in_data[IN_WIDTH-1] ? -in_data : in_data;

    logic [LZC_W-1:0]    lzc;
    logic [IN_WIDTH-1:0] norm;

    arith_lzc #(.WIDTH(IN_WIDTH), .CNT_W(LZC_W)) u_lzc (
        .value(s1_mag),
        .count(lzc)
    );

    assign norm = s1_mag << lzc;

    logic [EXT_W-1:0]  ext;
    logic [MANT_W-1:0] mant;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [MANT_W:0]   mant_sum;
    logic [EXP_W-1:0]  exp_val;
    logic [OUT_WIDTH-1:0] packed_fp;

    // Zero padding lets narrow inputs (exact conversions) share the wide rounding path.
    always_comb begin
        ext      = {s2_frac, {(MANT_W + 2){1'b0}}};
        mant     = ext[EXT_W-1 -: MANT_W];
        guard    = ext[EXT_W-1-MANT_W];
        sticky   = |ext[EXT_W-2-MANT_W:0];
        round_up = guard && (sticky || mant[0]);
        mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
        exp_val  = EXP_W'(BIAS + IN_WIDTH - 1) - EXP_W'(s2_lzc) + EXP_W'(mant_sum[MANT_W]);
        packed_fp = s2_zero ? '0 : {s2_sign, exp_val, mant_sum[MANT_W-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b1;
            s2_lzc   <= '0;
            s2_frac  <= '0;
            s3_valid <= 1'b0;
            s3_data  <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign <= in_data[IN_WIDTH-1];
                    s1_mag  <= mag_in;
                end
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sign <= s1_sign;
                    s2_zero <= ~norm[IN_WIDTH-1];
                    s2_lzc  <= lzc;
                    s2_frac <= norm[IN_WIDTH-2:0];
                end
            end
            if (s3_ready) begin
                s3_valid <= s2_valid;
                if (s2_valid) s3_data <= packed_fp;
            end
        end
    end

    assign io.result_valid = s3_valid;
    assign io.result_data  = s3_data;

endmodule
